contador_cascata_modn: RTL and testbench



---
 rtl/contador_pkg.sv | 19 +
 rtl/contador_cascata_modn_digito.sv | 51 +++++
 rtl/contador_cascata_modn.sv | 113 +++++++++++
 tb/tb_contador_cascata_modn.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and helpers for the cascaded modulo-N counter.
// Imported by the per-digit cell and the top-level sequencer.
package contador_pkg;

   typedef enum logic {
      ST_COUNT   = 1'b0,
      ST_EXPIRED = 1'b1
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Saturate an out-of-range load value to the largest legal digit.
   function automatic logic [31:0] clamp_digit(input logic [31:0] value,
                                               input logic [31:0] modulus);
      return (value >= modulus) ? (modulus - 32'd1) : value;
   endfunction

endpackage

// File: rtl/contador_cascata_modn_digito.sv
// One modulo-MOD digit cell: load with clamping, whole-counter wrap,
// single up/down step, and a per-direction terminal flag for the chain.
module contador_digito
   import contador_pkg::*;
#(
   parameter int DIG_W = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIG_W-1:0] data_dig,
   input  logic             step,
   input  logic             up,
   input  logic             wrap_all,
   output logic [DIG_W-1:0] value,
   output logic             at_term
);

   localparam logic [DIG_W-1:0] TERM_UP = DIG_W'(MOD - 1);

   logic [DIG_W-1:0] value_reg;
   logic [DIG_W-1:0] value_next;

   always_comb begin
      value_next = value_reg;
      if (load) begin
         value_next = DIG_W'(clamp_digit(32'(data_dig), 32'(MOD)));
      end else if (wrap_all) begin
         value_next = (up == DIR_UP) ? '0 : TERM_UP;
      end else if (step) begin
         if (up == DIR_UP) begin
            value_next = (value_reg >= TERM_UP) ? '0 : value_reg + 1'b1;
         end else begin
            value_next = (value_reg == '0) ? TERM_UP : value_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_reg <= '0;
      end else begin
         value_reg <= value_next;
      end
   end

   assign value   = value_reg;
   assign at_term = (up == DIR_UP) ? (value_reg == TERM_UP) : (value_reg == '0);

endmodule

// File: rtl/contador_cascata_modn.sv
// Cascaded modulo-N up/down counter: digit cells chained by terminal flags,
// with wrap or one-shot expiry handled by a two-state FSM and a done pulse.
module contador_cascata_modn
   import contador_pkg::*;
#(
   parameter int DIGITS  = 2,
   parameter int DIG_W   = 4,
   parameter int MOD     = 10,
   parameter int MOD_TOP = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DIGITS*DIG_W-1:0] data,
   input  logic                    load,
   input  logic                    enable,
   input  logic                    up,
   input  logic                    one_shot,
   output logic [DIGITS*DIG_W-1:0] count,
   output logic                    tc,
   output logic                    done,
   output logic                    expired
);

   // Digit 0 uses MOD_TOP when it is also the top digit.
   localparam int MOD0 = (DIGITS == 1) ? MOD_TOP : MOD;
   localparam logic [DIG_W-1:0] PRE_UP   = DIG_W'(MOD0 - 2);
   localparam logic [DIG_W-1:0] PRE_DOWN = DIG_W'(1);

   state_t            state_reg;
   state_t            state_next;
   logic              done_reg;
   logic              done_next;
   logic [DIGITS-1:0] at_term;
   logic [DIGITS-1:0] chain;
   logic [DIGITS-1:0] step_vec;
   logic              step_en;
   logic              wrap_all;
   logic              upper_term;
   logic              lands_term;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_first
            assign chain[gi] = 1'b1;
         end else begin : g_rest
            assign chain[gi] = chain[gi-1] & at_term[gi-1];
         end

         assign step_vec[gi] = step_en & chain[gi];

         contador_digito #(
            .DIG_W (DIG_W),
            .MOD   ((gi == DIGITS - 1) ? MOD_TOP : MOD)
         ) u_digito (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .data_dig (data[gi*DIG_W +: DIG_W]),
            .step     (step_vec[gi]),
            .up       (up),
            .wrap_all (wrap_all),
            .value    (count[gi*DIG_W +: DIG_W]),
            .at_term  (at_term[gi])
         );
      end
   endgenerate

   assign tc = &at_term;

   // A one-shot step lands on terminal only when digit 0 is one step away
   // and every higher digit already sits at its terminal value.
   assign upper_term = &(at_term | DIGITS'(1));
   assign lands_term = upper_term &&
                       (count[DIG_W-1:0] == ((up == DIR_UP) ? PRE_UP : PRE_DOWN));

   assign step_en  = !load && enable && (state_reg == ST_COUNT) && !(one_shot && tc);
   assign wrap_all = step_en && tc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_COUNT;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      if (load) begin
         state_next = ST_COUNT;
      end else if ((state_reg == ST_COUNT) && enable) begin
         if (tc) begin
            done_next = 1'b1;
            if (one_shot) begin
               state_next = ST_EXPIRED;
            end
         end else if (one_shot && lands_term) begin
            done_next  = 1'b1;
            state_next = ST_EXPIRED;
         end
      end
   end

   always_comb begin
      done    = done_reg;
      expired = (state_reg == ST_EXPIRED);
   end

endmodule

// File: tb/tb_contador_cascata_modn.sv
// Directed bench for the cascaded counter: a decimal 00..99 instance and a
// 00..59 instance share stimulus; each step checks against hand values.
module tb_contador_cascata_modn;

   logic       clk;
   logic       reset;
   logic [7:0] data;
   logic       load;
   logic       enable;
   logic       up;
   logic       one_shot;
   logic [7:0] count;
   logic       tc;
   logic       done;
   logic       expired;
   logic [7:0] count6;
   logic       tc6;
   logic       done6;
   logic       expired6;

   int tests = 0;
   int fails = 0;

   contador_cascata_modn #(.DIGITS(2), .DIG_W(4), .MOD(10), .MOD_TOP(10)) dut (
      .clk(clk), .reset(reset), .data(data), .load(load), .enable(enable),
      .up(up), .one_shot(one_shot), .count(count), .tc(tc), .done(done),
      .expired(expired)
   );

   contador_cascata_modn #(.DIGITS(2), .DIG_W(4), .MOD(10), .MOD_TOP(6)) dut6 (
      .clk(clk), .reset(reset), .data(data), .load(load), .enable(enable),
      .up(up), .one_shot(one_shot), .count(count6), .tc(tc6), .done(done6),
      .expired(expired6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      $display("[TB] t=%0t count=%h tc=%b done=%b exp=%b | count6=%h tc6=%b done6=%b exp6=%b",
               $time, count, tc, done, expired, count6, tc6, done6, expired6);
   endtask

   initial begin
      reset = 1'b1; data = 8'h00; load = 1'b0; enable = 1'b0;
      up = 1'b0; one_shot = 1'b0;
      #3;
      chk("rst_count", 32'(count), 32'h00);
      chk("rst_done", 32'(done), 0);
      chk("rst_expired", 32'(expired), 0);
      chk("rst_tc_down", 32'(tc), 1);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // Down, wrap, borrow 10 -> 09 -> 08
      load = 1'b1; data = 8'h10;
      tick();
      chk("t1_load10", 32'(count), 32'h10);
      load = 1'b0; enable = 1'b1;
      tick();
      chk("t1_borrow09", 32'(count), 32'h09);
      chk("t1_done0a", 32'(done), 0);
      tick();
      chk("t1_08", 32'(count), 32'h08);
      chk("t1_done0b", 32'(done), 0);

      // Down wrap from 00
      load = 1'b1; data = 8'h00; enable = 1'b0;
      tick();
      chk("t2_load00", 32'(count), 32'h00);
      chk("t2_tc1", 32'(tc), 1);
      load = 1'b0; enable = 1'b1;
      tick();
      chk("t2_wrap99", 32'(count), 32'h99);
      chk("t2_done1", 32'(done), 1);
      chk("t2_tc0", 32'(tc), 0);
      tick();
      chk("t2_98", 32'(count), 32'h98);
      chk("t2_done_once", 32'(done), 0);

      // One-shot down from 02
      one_shot = 1'b1; load = 1'b1; data = 8'h02; enable = 1'b0;
      tick();
      load = 1'b0; enable = 1'b1;
      tick();
      chk("t3_01", 32'(count), 32'h01);
      chk("t3_exp0", 32'(expired), 0);
      chk("t3_done0", 32'(done), 0);
      tick();
      chk("t3_00", 32'(count), 32'h00);
      chk("t3_done1", 32'(done), 1);
      chk("t3_exp1", 32'(expired), 1);
      tick();
      chk("t3_hold00", 32'(count), 32'h00);
      chk("t3_done_once", 32'(done), 0);
      chk("t3_still_exp", 32'(expired), 1);
      load = 1'b1; data = 8'h05;
      tick();
      chk("t3_reload05", 32'(count), 32'h05);
      chk("t3_back_count", 32'(expired), 0);
      load = 1'b0;
      tick();
      chk("t3_resume04", 32'(count), 32'h04);

      // One-shot step attempted while already at terminal
      load = 1'b1; data = 8'h00; enable = 1'b0;
      tick();
      chk("t3b_exp0", 32'(expired), 0);
      load = 1'b0; enable = 1'b1;
      tick();
      chk("t3b_00", 32'(count), 32'h00);
      chk("t3b_done1", 32'(done), 1);
      chk("t3b_exp1", 32'(expired), 1);
      tick();
      chk("t3b_done0", 32'(done), 0);

      // Mod-60 top digit, up, wrap
      one_shot = 1'b0; up = 1'b1; load = 1'b1; data = 8'h58; enable = 1'b0;
      tick();
      chk("t4_load58", 32'(count6), 32'h58);
      load = 1'b0; enable = 1'b1;
      tick();
      chk("t4_59", 32'(count6), 32'h59);
      chk("t4_tc1", 32'(tc6), 1);
      chk("t4_done0", 32'(done6), 0);
      tick();
      chk("t4_wrap00", 32'(count6), 32'h00);
      chk("t4_done1", 32'(done6), 1);
      chk("t4_tc0", 32'(tc6), 0);
      tick();
      chk("t4_01", 32'(count6), 32'h01);
      chk("t4_done_once", 32'(done6), 0);

      // Mod-60 one-shot up landing on 59
      one_shot = 1'b1; load = 1'b1; data = 8'h57; enable = 1'b0;
      tick();
      load = 1'b0; enable = 1'b1;
      tick();
      chk("t4b_58", 32'(count6), 32'h58);
      chk("t4b_exp0", 32'(expired6), 0);
      tick();
      chk("t4b_59", 32'(count6), 32'h59);
      chk("t4b_done1", 32'(done6), 1);
      chk("t4b_exp1", 32'(expired6), 1);
      tick();
      chk("t4b_hold59", 32'(count6), 32'h59);
      chk("t4b_done0", 32'(done6), 0);

      // Clamp, load beats enable, hold
      one_shot = 1'b0; up = 1'b0; load = 1'b1; data = 8'hC3; enable = 1'b0;
      tick();
      chk("t5_clamp93", 32'(count), 32'h93);
      chk("t5_clamp53", 32'(count6), 32'h53);
      data = 8'h48; enable = 1'b1;
      tick();
      chk("t5_load_wins", 32'(count), 32'h48);
      load = 1'b0; enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t5_hold%0d", i), 32'(count), 32'h48);
         chk($sformatf("t5_hold_done%0d", i), 32'(done), 0);
      end
      enable = 1'b1;
      tick();
      chk("t6_at47", 32'(count), 32'h47);

      // Asynchronous reset between edges
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_count", 32'(count), 32'h00);
      chk("t6_async_done", 32'(done), 0);
      chk("t6_async_exp", 32'(expired), 0);
      #2;
      reset = 1'b0;
      tick();
      chk("t6_resume99", 32'(count), 32'h99);
      chk("t6_resume_done", 32'(done), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
